// File: rtl/morse_pkg.sv
// Symbol codes shared with the decoder FSM, plus classifier state encodings.
package morse_pkg;

  localparam logic [1:0] SYM_NONE = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;
  localparam logic [1:0] SYM_EOC  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    MARK  = 2'b01,
    SPACE = 2'b10
  } state_e;

endpackage

// File: rtl/morse_symbol_classifier_key_debounce.sv
// Two-flop synchroniser followed by a tick-paced debouncer for the key line.
module key_debounce #(
  parameter int unsigned DEBOUNCE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din,
  output logic dout
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE + 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_key_db;
  logic [DB_W-1:0] r_db_cnt;
  logic [DB_W-1:0] w_db_cnt_inc;

  assign w_db_cnt_inc = r_db_cnt + DB_W'(1);
  assign dout         = r_key_db;

  // Bring the asynchronous key into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
    end
  end

  // Flip the debounced key only after DEBOUNCE consecutive disagreeing ticks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key_db <= 1'b0;
      r_db_cnt <= '0;
    end else if (tick) begin
      if (r_sync2 != r_key_db) begin
        if (w_db_cnt_inc == DB_W'(DEBOUNCE)) begin
          r_key_db <= ~r_key_db;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= w_db_cnt_inc;
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/morse_symbol_classifier.sv
// Turns the debounced key into dot/dash/end-of-character codes, one per tick.
module morse_symbol_classifier
  import morse_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned DEBOUNCE = 2,
  parameter int unsigned DASH_MIN = 3,
  parameter int unsigned CHAR_GAP = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       serial_inp,
  output logic [1:0] parallel_out,
  output logic       sym_valid
);

  logic             w_key_db;
  logic [CNT_W-1:0] w_len_inc;
  logic [CNT_W-1:0] w_gap_inc;

  state_e           r_state;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_gap;
  logic [1:0]       r_code;
  logic             r_sym_valid;

  key_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_key_debounce (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .din  (serial_inp),
    .dout (w_key_db)
  );

  // Saturating increments so long marks/spaces never wrap.
  assign w_len_inc = (r_len == {CNT_W{1'b1}}) ? r_len : r_len + CNT_W'(1);
  assign w_gap_inc = (r_gap == {CNT_W{1'b1}}) ? r_gap : r_gap + CNT_W'(1);

  assign parallel_out = r_code;
  assign sym_valid    = r_sym_valid;

  // Classifier FSM: advances on tick only; code held for a full tick interval.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_gap       <= '0;
      r_code      <= SYM_NONE;
      r_sym_valid <= 1'b0;
    end else begin
      r_sym_valid <= 1'b0;
      if (tick) begin
        r_code <= SYM_NONE;
        case (r_state)
          IDLE: begin
            if (w_key_db) begin
              r_state <= MARK;
              r_len   <= CNT_W'(1);
            end
          end
          MARK: begin
            if (w_key_db) begin
              r_len <= w_len_inc;
            end else begin
              r_code      <= (r_len < CNT_W'(DASH_MIN)) ? SYM_DOT : SYM_DASH;
              r_sym_valid <= 1'b1;
              r_state     <= SPACE;
              r_gap       <= CNT_W'(1);
            end
          end
          SPACE: begin
            if (w_key_db) begin
              r_state <= MARK;
              r_len   <= CNT_W'(1);
            end else begin
              r_gap <= w_gap_inc;
              if (w_gap_inc == CNT_W'(CHAR_GAP)) begin
                r_code      <= SYM_EOC;
                r_sym_valid <= 1'b1;
                r_state     <= IDLE;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_symbol_classifier.sv
// Self-checking bench: directed Morse scenarios plus random key streams,
// compared tick by tick against a run-length reference model.
module tb_morse_symbol_classifier;
  import morse_pkg::*;

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned DEBOUNCE = 2;
  localparam int unsigned DASH_MIN = 3;
  localparam int unsigned CHAR_GAP = 3;
  localparam int unsigned SAT      = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       serial_inp;
  logic [1:0] parallel_out;
  logic       sym_valid;

  int checks = 0;
  int errors = 0;

  // Reference model state, in terms of run lengths rather than FSM states.
  bit  m_db;
  int  m_disagree;
  int  m_mark_len;
  int  m_gap_len;
  bit  m_in_char;
  logic [1:0] m_prev_code;

  // Codes actually observed on the DUT whenever sym_valid was seen high.
  logic [1:0] dut_emit[$];

  always #5 clk = ~clk;

  morse_symbol_classifier #(
    .CNT_W    (CNT_W),
    .DEBOUNCE (DEBOUNCE),
    .DASH_MIN (DASH_MIN),
    .CHAR_GAP (CHAR_GAP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .serial_inp   (serial_inp),
    .parallel_out (parallel_out),
    .sym_valid    (sym_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_db        = 1'b0;
    m_disagree  = 0;
    m_mark_len  = 0;
    m_gap_len   = 0;
    m_in_char   = 1'b0;
    m_prev_code = SYM_NONE;
  endtask

  // One tick of the reference: classify with the debounced key seen so far,
  // then fold the new raw key sample into the debouncer.
  task automatic model_tick(input bit key, output logic [1:0] code);
    code = SYM_NONE;
    if (m_db) begin
      if (m_mark_len > 0) m_mark_len = (m_mark_len + 1 > SAT) ? SAT : m_mark_len + 1;
      else                m_mark_len = 1;
      m_in_char = 1'b1;
    end else if (m_mark_len > 0) begin
      code        = (m_mark_len < DASH_MIN) ? SYM_DOT : SYM_DASH;
      m_mark_len  = 0;
      m_gap_len   = 1;
    end else if (m_in_char) begin
      m_gap_len = (m_gap_len + 1 > SAT) ? SAT : m_gap_len + 1;
      if (m_gap_len == CHAR_GAP) begin
        code      = SYM_EOC;
        m_in_char = 1'b0;
      end
    end
    if (key != m_db) begin
      m_disagree++;
      if (m_disagree == DEBOUNCE) begin
        m_db       = key;
        m_disagree = 0;
      end
    end else begin
      m_disagree = 0;
    end
  endtask

  // One tick period (4 clk): drive key, check the sym_valid clear from the
  // previous tick, then check the tick cycle itself.
  task automatic step(input bit key);
    logic [1:0] exp_code;
    @(negedge clk);
    serial_inp = key;
    tick       = 1'b0;
    @(posedge clk);
    #1;
    chk("valid_clear", 32'(sym_valid), 32'(0));
    chk("code_hold", 32'(parallel_out), 32'(m_prev_code));
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1;
    model_tick(key, exp_code);
    chk("tick_code", 32'(parallel_out), 32'(exp_code));
    chk("tick_valid", 32'(sym_valid), 32'(exp_code != SYM_NONE));
    if (sym_valid === 1'b1) dut_emit.push_back(parallel_out);
    m_prev_code = exp_code;
  endtask

  task automatic run(input bit key, input int n);
    for (int i = 0; i < n; i++) step(key);
  endtask

  task automatic expect_emits(input string tag, input logic [1:0] exp[$]);
    chk({tag, "_count"}, 32'(dut_emit.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < dut_emit.size(); i++)
      chk({tag, "_code"}, 32'(dut_emit[i]), 32'(exp[i]));
    dut_emit.delete();
  endtask

  initial begin
    logic [1:0] exp_q[$];
    rst        = 1'b0;
    tick       = 1'b0;
    serial_inp = 1'b0;
    model_reset();
    #1;
    chk("reset_code", 32'(parallel_out), 32'(SYM_NONE));
    chk("reset_valid", 32'(sym_valid), 32'(0));
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Startup and glitch: a single-tick pulse is filtered away.
    run(0, 20); run(1, 1); run(0, 30);
    exp_q = {};
    expect_emits("glitch", exp_q);

    // Dot then gap.
    run(1, 2); run(0, 5);
    exp_q = {SYM_DOT, SYM_EOC};
    expect_emits("dot", exp_q);

    // Dash.
    run(1, 5); run(0, 5);
    exp_q = {SYM_DASH, SYM_EOC};
    expect_emits("dash", exp_q);

    // Letter A: shortest space the debouncer passes keeps it one character.
    run(1, 2); run(0, 2); run(1, 4); run(0, 6);
    exp_q = {SYM_DOT, SYM_DASH, SYM_EOC};
    expect_emits("letter_a", exp_q);

    // Saturated mark, then a long space: one dash, one end-of-character.
    run(1, 300); run(0, 20);
    exp_q = {SYM_DASH, SYM_EOC};
    expect_emits("saturate", exp_q);

    // Random key streams against the reference.
    for (int r = 0; r < 120; r++) begin
      run(1, $urandom_range(1, 6));
      run(0, $urandom_range(1, 5));
    end
    run(0, 8);
    dut_emit.delete();

    // Reset mid-mark discards the mark.
    run(1, 4);
    @(negedge clk);
    tick = 1'b0;
    rst  = 1'b0;
    #1;
    chk("midreset_code", 32'(parallel_out), 32'(SYM_NONE));
    chk("midreset_valid", 32'(sym_valid), 32'(0));
    repeat (3) @(negedge clk);
    serial_inp = 1'b0;
    rst        = 1'b1;
    model_reset();
    run(0, 12);
    exp_q = {};
    expect_emits("midreset", exp_q);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
